mem_access_ctrl: RTL and testbench

//  Memory-cycle sequencer sitting directly upstream of the memory buffer register (MBR).

---
 rtl/mem_ctrl_pkg.sv | 21 ++
 rtl/wait_state_ctr.sv | 46 ++++
 rtl/mem_access_ctrl.sv | 139 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared encodings for the memory access sequencer
// Purpose: state encoding and MBR control words {src, en_read, en}.
// Ports: none (package).
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_WAIT = 3'd2,
        ST_XFER = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    // {mbr_data_src, mbr_en_read, mbr_en}
    localparam logic [2:0] MBR_LOAD_BUS = 3'b111;
    localparam logic [2:0] MBR_LOAD_RAM = 3'b011;
    localparam logic [2:0] MBR_DRV_BUS  = 3'b101;
    localparam logic [2:0] MBR_DRV_RAM  = 3'b001;
    localparam logic [2:0] MBR_OFF      = 3'b000;

endpackage

// File: rtl/wait_state_ctr.sv
// rtl/wait_state_ctr.sv - saturating down-counter for access wait states
// Purpose: holds ws_cnt; loaded at accept, decremented once per WAIT cycle.
// Ports:
//   clk, reset      clock, synchronous active-high reset (count -> 0)
//   load, load_val  load the count (has priority over dec)
//   dec             decrement, saturating at zero
//   cnt_zero        current count is zero
//   zero_next       count after a saturating decrement would be zero
module wait_state_ctr #(
    parameter int WS_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [WS_W-1:0] load_val,
    input  logic            dec,
    output logic            cnt_zero,
    output logic            zero_next
);

    logic [WS_W-1:0] cnt_q;
    logic [WS_W-1:0] cnt_d;
    logic [WS_W-1:0] cnt_dec;

    always_comb begin
        cnt_dec = (cnt_q == '0) ? '0 : cnt_q - WS_W'(1);
        cnt_d   = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec) begin
            cnt_d = cnt_dec;
        end
    end

    assign cnt_zero  = (cnt_q == '0);
    assign zero_next = (cnt_dec == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - memory-cycle sequencer driving RAM strobes and MBR controls
// Purpose: accepts one read/write request at a time, holds the address in MAR and
//   sequences IDLE -> ADDR -> [WAIT*] -> XFER -> FIN with programmable wait states
//   plus READY extension. All outputs decode from registered state, write flag, count.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready             request handshake (ready only in IDLE, reset low)
//   req_write, req_addr             request type and address, sampled at accept
//   ram_ready                       RAM ready; low stretches WAIT
//   done, busy                      last-cycle pulse, not-idle flag
//   mem_addr                        MAR contents
//   ram_cs, ram_oe, ram_we          RAM strobes
//   mbr_data_src/en_read/en         MBR controls
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 1,
    parameter int WS_W        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              ram_ready,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              ram_cs,
    output logic              ram_oe,
    output logic              ram_we,
    output logic              mbr_data_src,
    output logic              mbr_en_read,
    output logic              mbr_en
);

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic              accept;
    logic              ws_load;
    logic              ws_dec;
    logic              ws_zero;
    logic              ws_zero_next;
    logic [2:0]        mbr_ctl;

    wait_state_ctr #(.WS_W(WS_W)) u_ws (
        .clk       (clk),
        .reset     (reset),
        .load      (ws_load),
        .load_val  (WS_W'(WAIT_STATES)),
        .dec       (ws_dec),
        .cnt_zero  (ws_zero),
        .zero_next (ws_zero_next)
    );

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        mar_d   = mar_q;
        ws_load = 1'b0;
        ws_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mar_d   = req_addr;
                    wr_d    = req_write;
                    ws_load = 1'b1;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: state_d = (!ws_zero || !ram_ready) ? ST_WAIT : ST_XFER;
            ST_WAIT: begin
                // Leave only once the post-decrement count is zero and RAM is ready.
                ws_dec = 1'b1;
                if (ws_zero_next && ram_ready) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            mar_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            mar_q   <= mar_d;
        end
    end

    always_comb begin
        done    = 1'b0;
        ram_cs  = 1'b0;
        ram_oe  = 1'b0;
        ram_we  = 1'b0;
        mbr_ctl = MBR_OFF;
        case (state_q)
            ST_ADDR: begin
                ram_cs  = 1'b1;
                ram_oe  = !wr_q;
                mbr_ctl = wr_q ? MBR_LOAD_BUS : MBR_OFF;
            end
            ST_WAIT: begin
                // Write data is already on ram_data for setup; strobe comes in XFER.
                ram_cs  = 1'b1;
                ram_oe  = !wr_q;
                mbr_ctl = wr_q ? MBR_DRV_RAM : MBR_OFF;
            end
            ST_XFER: begin
                ram_cs  = 1'b1;
                ram_oe  = !wr_q;
                ram_we  = wr_q;
                mbr_ctl = wr_q ? MBR_DRV_RAM : MBR_LOAD_RAM;
            end
            ST_FIN: begin
                done    = 1'b1;
                mbr_ctl = wr_q ? MBR_DRV_RAM : MBR_DRV_BUS;
            end
            default: mbr_ctl = MBR_OFF;
        endcase
    end

    assign {mbr_data_src, mbr_en_read, mbr_en} = mbr_ctl;
    assign busy     = (state_q != ST_IDLE);
    assign mem_addr = mar_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    localparam int WS = 1;
    localparam int PH_ADDR = 0, PH_WAIT = 1, PH_XFER = 2, PH_FIN = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_valid0 = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        ram_ready = 1'b1;

    logic        req_ready, done, busy, ram_cs, ram_oe, ram_we;
    logic        mbr_data_src, mbr_en_read, mbr_en;
    logic [15:0] mem_addr;
    logic        d0_ready, d0_done, d0_busy, d0_cs, d0_oe, d0_we, d0_src, d0_enr, d0_en;
    logic [15:0] d0_addr;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(16), .WAIT_STATES(WS), .WS_W(4)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .ram_ready(ram_ready),
        .done(done), .busy(busy), .mem_addr(mem_addr), .ram_cs(ram_cs),
        .ram_oe(ram_oe), .ram_we(ram_we), .mbr_data_src(mbr_data_src),
        .mbr_en_read(mbr_en_read), .mbr_en(mbr_en)
    );

    mem_access_ctrl #(.ADDR_W(16), .WAIT_STATES(0), .WS_W(4)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(d0_ready),
        .req_write(req_write), .req_addr(req_addr), .ram_ready(ram_ready),
        .done(d0_done), .busy(d0_busy), .mem_addr(d0_addr), .ram_cs(d0_cs),
        .ram_oe(d0_oe), .ram_we(d0_we), .mbr_data_src(d0_src),
        .mbr_en_read(d0_enr), .mbr_en(d0_en)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // MBR register, RAM array and bus resolution driven by the DUT controls.
    logic [7:0] mbr_q = '0;
    logic [7:0] ram_arr [256];
    logic [7:0] sb [256];
    logic       mbr_drv_bus, mbr_drv_ram;
    logic [7:0] data_bus_v, ram_data_v;

    assign mbr_drv_bus = mbr_en && !mbr_en_read && mbr_data_src;
    assign mbr_drv_ram = mbr_en && !mbr_en_read && !mbr_data_src;
    assign data_bus_v  = mbr_drv_bus ? mbr_q : req_wdata;
    assign ram_data_v  = mbr_drv_ram ? mbr_q :
                         ((ram_cs && ram_oe) ? ram_arr[mem_addr[7:0]] : 8'h00);

    always @(posedge clk) begin
        if (mbr_en && mbr_en_read) mbr_q <= mbr_data_src ? data_bus_v : ram_data_v;
        if (ram_cs && ram_we) ram_arr[mem_addr[7:0]] <= ram_data_v;
    end

    // Reference model: one access in flight, described by its phase and remaining waits.
    logic        m_busy = 1'b0;
    int          m_ph = PH_ADDR;
    logic        m_wr = 1'b0;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_wdata = '0;
    int          m_ws = 0;

    always @(posedge clk) begin
        if (m_busy && m_ph == PH_XFER && m_wr) sb[m_addr[7:0]] <= m_wdata;
        if (reset) begin
            m_busy <= 1'b0;
            m_addr <= '0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy <= 1'b1;
                m_ph   <= PH_ADDR;
                m_wr   <= req_write;
                m_addr <= req_addr;
                m_ws   <= WS;
            end
        end else begin
            case (m_ph)
                PH_ADDR: begin
                    if (m_wr) m_wdata <= req_wdata;
                    m_ph <= (m_ws > 0 || !ram_ready) ? PH_WAIT : PH_XFER;
                end
                PH_WAIT: begin
                    int n;
                    n = (m_ws > 0) ? m_ws - 1 : 0;
                    m_ws <= n;
                    if (n == 0 && ram_ready) m_ph <= PH_XFER;
                end
                PH_XFER: m_ph <= PH_FIN;
                default: m_busy <= 1'b0;
            endcase
        end
    end

    // {req_ready, done, busy, cs, oe, we, src, en_read, en}
    function automatic logic [8:0] exp_vec();
        logic [8:0] v;
        v = '0;
        if (!m_busy) v[8] = !reset;
        else begin
            v[6] = 1'b1;
            case (m_ph)
                PH_ADDR: v[5:0] = m_wr ? 6'b100_111 : 6'b110_000;
                PH_WAIT: v[5:0] = m_wr ? 6'b100_001 : 6'b110_000;
                PH_XFER: v[5:0] = m_wr ? 6'b101_001 : 6'b110_011;
                default: begin v[7] = 1'b1; v[2:0] = m_wr ? 3'b001 : 3'b101; end
            endcase
        end
        return v;
    endfunction

    logic chk_en = 1'b0;
    int   n_done_dut = 0, n_fin_mdl = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ctl_vec", 32'({req_ready, done, busy, ram_cs, ram_oe, ram_we,
                                mbr_data_src, mbr_en_read, mbr_en}), 32'(exp_vec()));
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            chk("we_oe_excl", 32'(ram_we & ram_oe), 32'd0);
            if (done) n_done_dut++;
            if (m_busy && m_ph == PH_FIN) begin
                n_fin_mdl++;
                if (!m_wr) chk("rd_data", 32'(data_bus_v), 32'(sb[m_addr[7:0]]));
                else       chk("wr_data", 32'(ram_arr[m_addr[7:0]]), 32'(sb[m_addr[7:0]]));
            end
        end
    end

    int          done_at;
    logic [31:0] we_mask, oe_mask;
    logic [7:0]  rd_obs [32];
    logic [7:0]  fin_bus;
    logic [15:0] fin_addr;

    task automatic run_acc(input logic wr, input logic [15:0] a, input logic [7:0] wd,
                           input int lo_s, input int lo_n);
        int w;
        req_write = wr; req_addr = a; req_wdata = wd; req_valid = 1'b1; ram_ready = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin tick(); w++; end
        done_at = -1; we_mask = '0; oe_mask = '0; fin_bus = '0; fin_addr = '0;
        for (int k = 0; k < 32; k++) begin
            ram_ready = !(k >= lo_s && k < lo_s + lo_n);
            if (k == 1) req_valid = 1'b0;
            we_mask[k] = ram_we;
            oe_mask[k] = ram_oe;
            rd_obs[k]  = ram_data_v;
            if (done) begin
                done_at = k; fin_bus = data_bus_v; fin_addr = mem_addr;
                break;
            end
            tick();
        end
        ram_ready = 1'b1;
        tick();
    endtask

    int acc_c [4];
    int done_c [4];
    int n_acc, n_dn;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_arr[i] = 8'(i) ^ 8'h5A;
            sb[i]      = 8'(i) ^ 8'h5A;
        end
        ram_arr[8'h50] = 8'hA5; sb[8'h50] = 8'hA5;
        tick();
        chk_en = 1'b1;
        tick(); tick();
        chk("reset_ready_low", 32'(req_ready), 32'd0);
        chk("reset_outputs", 32'({done, busy, ram_cs, ram_oe, ram_we, mbr_en, mem_addr}), 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // Read, ram_ready high throughout
        run_acc(1'b0, 16'h2050, 8'h00, 99, 0);
        chk("t2_done_at", 32'(done_at), 32'd4);
        chk("t2_addr", 32'(fin_addr), 32'h2050);
        chk("t2_bus", 32'(fin_bus), 32'hA5);

        // Write
        run_acc(1'b1, 16'h00FF, 8'h3C, 99, 0);
        chk("t3_done_at", 32'(done_at), 32'd4);
        chk("t3_we_mask", we_mask, 32'h8);
        for (int k = 2; k <= 4; k++) chk("t3_ram_data", 32'(rd_obs[k]), 32'h3C);
        chk("t3_ram_cell", 32'(ram_arr[8'hFF]), 32'h3C);

        // Read stretched three cycles in WAIT
        run_acc(1'b0, 16'h1111, 8'h00, 2, 3);
        chk("t4_done_at", 32'(done_at), 32'd7);
        chk("t4_oe_mask", oe_mask, 32'h7E);

        // Reset for two cycles during WAIT
        req_write = 1'b0; req_addr = 16'h1234; req_valid = 1'b1; ram_ready = 1'b0;
        tick(); req_valid = 1'b0;
        tick();
        chk("t1_in_wait", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        chk("t1_all_zero", 32'({req_ready, done, busy, ram_cs, ram_oe, ram_we,
                                mbr_data_src, mbr_en_read, mbr_en, mem_addr}), 32'd0);
        tick();
        reset = 1'b0; ram_ready = 1'b1;
        #1;
        chk("t1_ready_after", 32'(req_ready), 32'd1);

        // WAIT_STATES=0 back-to-back read then write with req_valid held
        req_valid0 = 1'b1; req_write = 1'b0; req_addr = 16'h0400;
        n_acc = 0; n_dn = 0;
        for (int c = 0; c < 12; c++) begin
            if (d0_ready && req_valid0 && n_acc < 4) begin acc_c[n_acc] = c; n_acc++; end
            if (d0_done && n_dn < 4) begin done_c[n_dn] = c; n_dn++; end
            tick();
            if (n_acc == 1) begin req_write = 1'b1; req_addr = 16'h0401; end
            if (n_acc == 2) req_valid0 = 1'b0;
        end
        chk("t5_n_acc", 32'(n_acc), 32'd2);
        chk("t5_n_done", 32'(n_dn), 32'd2);
        chk("t5_acc0", 32'(acc_c[0]), 32'd0);
        chk("t5_acc1", 32'(acc_c[1]), 32'd4);
        chk("t5_done0", 32'(done_c[0]), 32'd3);
        chk("t5_done1", 32'(done_c[1]), 32'd7);

        // WAIT_STATES=0 read with ram_ready low in ADDR: one extra WAIT cycle
        req_valid0 = 1'b1; req_write = 1'b0; req_addr = 16'h0500;
        n_dn = -1;
        for (int c = 0; c < 12; c++) begin
            ram_ready = (c != 1);
            if (c == 1) req_valid0 = 1'b0;
            if (d0_done && n_dn < 0) n_dn = c;
            tick();
        end
        ram_ready = 1'b1;
        chk("t5b_done_at", 32'(n_dn), 32'd4);

        // Random traffic: req_valid toggles while busy, random ready and resets
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 79) == 0);
            req_valid = $urandom_range(0, 1) == 1;
            req_write = $urandom_range(0, 1) == 1;
            req_addr  = {8'($urandom), 4'h0, 4'($urandom)};
            req_wdata = 8'($urandom);
            ram_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset = 1'b0; req_valid = 1'b0; ram_ready = 1'b1;
        for (int i = 0; i < 30 && busy; i++) tick();
        chk("drain_idle", 32'(busy), 32'd0);
        chk("done_count", 32'(n_done_dut), 32'(n_fin_mdl));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
